ram_mfc_controller: RTL and testbench

- Memory-side responder to the control unit's RAM interface.
- Accepts a request on ramMFA: address, read/write, data size, write data.
- Performs a byte, halfword or word access on an internal byte-addressed big-endian array after a fixed latency.
- Signals completion with ramMFC, which the control unit waits on before advancing its state.

---
 rtl/ram_mfc_controller.sv | 172 +++++++++++++++++
 tb/tb_ram_mfc_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_mfc_controller.sv
// Memory-side responder for the control unit's RAM handshake: byte-addressed
// big-endian array, byte/halfword/word access completed after a fixed latency.
module ram_mfc_controller #(
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 2
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  ramMFA,
    input  logic                  ramRW,
    input  logic [1:0]            ramDataSize,
    input  logic [ADDR_WIDTH-1:0] ramAddress,
    input  logic [31:0]           dataIn,
    output logic [31:0]           dataOut,
    output logic                  ramMFC,
    output logic                  ramErr
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rw_q, rw_d;
    logic [1:0]            size_q, size_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           dout_q, dout_d;
    logic                  mfc_q, mfc_d;
    logic                  err_q, err_d;

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] lane_addr [4];
    logic [7:0]            rd_byte [4];
    logic [7:0]            wr_byte [4];
    logic [3:0]            wr_en;
    logic                  bad_req;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            lane_addr[i] = addr_q + ADDR_WIDTH'(i);
            rd_byte[i]   = mem[lane_addr[i]];
        end
    end

    always_comb begin
        unique case (size_q)
            2'b00:   bad_req = 1'b0;
            2'b01:   bad_req = addr_q[0];
            2'b10:   bad_req = (addr_q[1:0] != 2'b00);
            default: bad_req = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        err_d   = err_q;
        wr_en   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            wr_byte[i] = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (ramMFA) begin
                    addr_d  = ramAddress;
                    rw_d    = ramRW;
                    size_d  = ramDataSize;
                    wdata_d = dataIn;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    mfc_d   = 1'b1;
                    state_d = DONE;
                    if (bad_req) begin
                        err_d  = 1'b1;
                        dout_d = '0;
                    end else if (rw_q) begin
                        unique case (size_q)
                            2'b00:   dout_d = {24'b0, rd_byte[0]};
                            2'b01:   dout_d = {16'b0, rd_byte[0], rd_byte[1]};
                            default: dout_d = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
                        endcase
                    end else begin
                        // Big-endian: lane 0 (lowest address) takes the most significant byte.
                        unique case (size_q)
                            2'b00: begin
                                wr_en      = 4'b0001;
                                wr_byte[0] = wdata_q[7:0];
                            end
                            2'b01: begin
                                wr_en      = 4'b0011;
                                wr_byte[0] = wdata_q[15:8];
                                wr_byte[1] = wdata_q[7:0];
                            end
                            default: begin
                                wr_en      = 4'b1111;
                                wr_byte[0] = wdata_q[31:24];
                                wr_byte[1] = wdata_q[23:16];
                                wr_byte[2] = wdata_q[15:8];
                                wr_byte[3] = wdata_q[7:0];
                            end
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (!ramMFA) begin
                    mfc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            size_q  <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            err_q   <= err_d;
        end
    end

    // Array is never cleared; reset only suppresses a commit on the same edge.
    always_ff @(posedge Clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (reset && wr_en[i]) begin
                mem[lane_addr[i]] <= wr_byte[i];
            end
        end
    end

    assign dataOut = dout_q;
    assign ramMFC  = mfc_q;
    assign ramErr  = err_q;

endmodule

// File: tb/tb_ram_mfc_controller.sv
// Bench for ram_mfc_controller: three instances (LATENCY 2, 1, 4) checked every
// cycle against a transaction-level byte-array model, plus literal expectations.
module tb_ram_mfc_controller;

    localparam int AW = 9;
    localparam int NU = 3;

    function automatic int lat_of(input int u);
        return (u == 0) ? 2 : ((u == 1) ? 1 : 4);
    endfunction

    logic          Clk;
    logic          rst  [NU];
    logic          mfa  [NU];
    logic          rw   [NU];
    logic [1:0]    sz   [NU];
    logic [AW-1:0] addr [NU];
    logic [31:0]   din  [NU];
    logic [31:0]   dout [NU];
    logic          mfc  [NU];
    logic          err  [NU];

    for (genvar g = 0; g < NU; g++) begin : g_dut
        ram_mfc_controller #(
            .ADDR_WIDTH(AW),
            .LATENCY   (lat_of(g))
        ) u_dut (
            .Clk        (Clk),
            .reset      (rst[g]),
            .ramMFA     (mfa[g]),
            .ramRW      (rw[g]),
            .ramDataSize(sz[g]),
            .ramAddress (addr[g]),
            .dataIn     (din[g]),
            .dataOut    (dout[g]),
            .ramMFC     (mfc[g]),
            .ramErr     (err[g])
        );
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Transaction-level model: acceptance time + LATENCY gives completion time.
    int          cyc = 0;
    logic        m_mfc  [NU];
    logic        m_err  [NU];
    logic [31:0] m_dout [NU];
    bit          m_busy [NU];
    int          m_due  [NU];
    bit          m_rw   [NU];
    int          m_sz   [NU];
    int          m_a    [NU];
    logic [31:0] m_din  [NU];
    logic [7:0]  mdl    [NU][1 << AW];

    task automatic model_exec(input int u);
        int          n;
        bit          bad;
        logic [31:0] v;
        n   = (m_sz[u] == 0) ? 1 : ((m_sz[u] == 1) ? 2 : 4);
        bad = (m_sz[u] == 3) || ((m_a[u] % n) != 0);
        if (bad) begin
            m_err[u]  = 1'b1;
            m_dout[u] = 32'h0;
        end else if (m_rw[u]) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = (v << 8) | {24'b0, mdl[u][m_a[u] + i]};
            m_dout[u] = v;
        end else begin
            for (int i = 0; i < n; i++) mdl[u][m_a[u] + i] = 8'(m_din[u] >> (8 * (n - 1 - i)));
        end
    endtask

    initial forever begin
        @(posedge Clk);
        for (int u = 0; u < NU; u++) begin
            if (!rst[u]) begin
                m_mfc[u]  = 1'b0;
                m_err[u]  = 1'b0;
                m_dout[u] = 32'h0;
                m_busy[u] = 1'b0;
            end else if (m_mfc[u]) begin
                if (!mfa[u]) begin
                    m_mfc[u] = 1'b0;
                    m_err[u] = 1'b0;
                end
            end else if (m_busy[u]) begin
                if (cyc == m_due[u]) begin
                    model_exec(u);
                    m_busy[u] = 1'b0;
                    m_mfc[u]  = 1'b1;
                end
            end else if (mfa[u]) begin
                m_rw[u]   = rw[u];
                m_sz[u]   = int'(sz[u]);
                m_a[u]    = int'(addr[u]);
                m_din[u]  = din[u];
                m_busy[u] = 1'b1;
                m_due[u]  = cyc + lat_of(u);
            end
        end
        cyc++;
    end

    initial forever begin
        @(negedge Clk);
        if (chk_en) begin
            for (int u = 0; u < NU; u++) begin
                chk($sformatf("cyc_mfc[u%0d]", u), {31'b0, mfc[u]}, {31'b0, m_mfc[u]});
                chk($sformatf("cyc_err[u%0d]", u), {31'b0, err[u]}, {31'b0, m_err[u]});
                chk($sformatf("cyc_dout[u%0d]", u), dout[u], m_dout[u]);
            end
        end
    end

    task automatic txn(input int u, input bit r, input logic [1:0] s, input int a,
                       input logic [31:0] d, input int hold, input bit drop,
                       output logic [31:0] q, output logic e);
        int n;
        bit seen;
        @(negedge Clk);
        rw[u]   = r;
        sz[u]   = s;
        addr[u] = AW'(a);
        din[u]  = d;
        mfa[u]  = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge Clk);
            n++;
            if (drop) mfa[u] = 1'b0;
            if (mfc[u] === 1'b1) seen = 1'b1;
        end
        chk($sformatf("latency[u%0d]", u), seen ? 32'(n - 1) : 32'hFFFF_FFFF, 32'(lat_of(u)));
        q = dout[u];
        e = err[u];
        if (drop) begin
            @(negedge Clk);
            chk("mfc_one_cycle", {31'b0, mfc[u]}, 32'h0);
        end else begin
            repeat (hold) begin
                @(negedge Clk);
                chk("mfc_held", {31'b0, mfc[u]}, 32'h1);
            end
            mfa[u] = 1'b0;
            @(negedge Clk);
            chk("mfc_release", {31'b0, mfc[u]}, 32'h0);
        end
        mfa[u] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] q;
    logic        e;
    logic [31:0] pat;

    initial begin
        for (int u = 0; u < NU; u++) begin
            rst[u] = 1'b0; mfa[u] = 1'b0; rw[u] = 1'b0;
            sz[u] = 2'b00; addr[u] = '0; din[u] = 32'h0;
        end
        repeat (2) @(negedge Clk);
        for (int u = 0; u < NU; u++) begin
            chk("reset_mfc", {31'b0, mfc[u]}, 32'h0);
            chk("reset_err", {31'b0, err[u]}, 32'h0);
            chk("reset_dout", dout[u], 32'h0);
            rst[u] = 1'b1;
        end
        chk_en = 1'b1;

        txn(0, 1'b0, 2'b10, 'h010, 32'h11223344, 0, 1'b0, q, e);
        txn(0, 1'b1, 2'b10, 'h010, 32'h0, 0, 1'b0, q, e);
        chk("rd_word_010", q, 32'h11223344);
        chk("rd_word_010_err", {31'b0, e}, 32'h0);

        txn(0, 1'b1, 2'b00, 'h011, 32'h0, 0, 1'b0, q, e);
        chk("rd_byte_011", q, 32'h00000022);
        txn(0, 1'b1, 2'b01, 'h012, 32'h0, 0, 1'b0, q, e);
        chk("rd_half_012", q, 32'h00003344);
        txn(0, 1'b0, 2'b00, 'h013, 32'h000000AB, 0, 1'b0, q, e);
        txn(0, 1'b1, 2'b10, 'h010, 32'h0, 0, 1'b0, q, e);
        chk("rd_word_010_after_byte", q, 32'h112233AB);

        txn(0, 1'b0, 2'b10, 'h020, 32'h55667788, 0, 1'b0, q, e);
        txn(0, 1'b0, 2'b01, 'h021, 32'h0000FFFF, 0, 1'b0, q, e);
        chk("misalign_half_err", {31'b0, e}, 32'h1);
        chk("misalign_half_dout", q, 32'h0);
        txn(0, 1'b1, 2'b10, 'h022, 32'h0, 0, 1'b0, q, e);
        chk("misalign_word_err", {31'b0, e}, 32'h1);
        chk("misalign_word_dout", q, 32'h0);
        txn(0, 1'b1, 2'b10, 'h020, 32'h0, 0, 1'b0, q, e);
        chk("rd_020_unchanged", q, 32'h55667788);

        txn(0, 1'b0, 2'b11, 'h020, 32'hFFFFFFFF, 0, 1'b0, q, e);
        chk("reserved_size_err", {31'b0, e}, 32'h1);
        txn(0, 1'b1, 2'b10, 'h020, 32'h0, 5, 1'b0, q, e);
        chk("rd_020_after_reserved", q, 32'h55667788);

        txn(0, 1'b0, 2'b10, 'h030, 32'hCAFEBABE, 0, 1'b1, q, e);
        txn(0, 1'b1, 2'b10, 'h030, 32'h0, 0, 1'b0, q, e);
        chk("rd_030_after_drop", q, 32'hCAFEBABE);

        @(negedge Clk);
        rw[0] = 1'b0; sz[0] = 2'b10; addr[0] = AW'('h010); din[0] = 32'hDEADBEEF; mfa[0] = 1'b1;
        @(negedge Clk);
        rst[0] = 1'b0;
        mfa[0] = 1'b0;
        @(negedge Clk);
        chk("rst_busy_mfc", {31'b0, mfc[0]}, 32'h0);
        rst[0] = 1'b1;
        @(negedge Clk);
        chk("rst_busy_mfc_after", {31'b0, mfc[0]}, 32'h0);
        txn(0, 1'b1, 2'b10, 'h010, 32'h0, 0, 1'b0, q, e);
        chk("rd_010_after_rst", q, 32'h112233AB);

        for (int u = 1; u < NU; u++) begin
            for (int a = 0; a < 512; a += 4) begin
                pat = (32'h9E3779B9 * 32'(a + 1)) ^ 32'(u);
                txn(u, 1'b0, 2'b10, a, pat, 0, 1'b0, q, e);
                txn(u, 1'b1, 2'b10, a, 32'h0, 0, 1'b0, q, e);
                chk($sformatf("sweep_word[u%0d]", u), q, pat);
                if (a % 16 == 8) begin
                    txn(u, 1'b1, 2'b00, a + 1, 32'h0, 0, 1'b0, q, e);
                    chk($sformatf("sweep_byte[u%0d]", u), q, {24'b0, pat[23:16]});
                    txn(u, 1'b1, 2'b01, a + 2, 32'h0, 0, 1'b0, q, e);
                    chk($sformatf("sweep_half[u%0d]", u), q, {16'b0, pat[15:0]});
                end
            end
        end

        repeat (2) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
